// File: rtl/data_mem_bank.sv
// data_mem_bank: single-port data memory with a valid/ready request port,
// byte-lane write masking, a one-cycle registered read response and a
// built-in clear sequencer that zeroes the whole array after reset or on
// demand, so no memory image file is ever needed.
module data_mem_bank #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [DATA_W/8-1:0]   req_be_i,
    input  logic [ADDR_W-1:0]     req_addr_i,
    input  logic [DATA_W-1:0]     req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [DATA_W-1:0]     rsp_rdata_o,
    input  logic                  clear_start_i,
    output logic                  busy_o
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    // Last address of the array; reaching it ends a clear sequence.
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_e;

    state_e              state_q;
    state_e              state_d;
    logic [ADDR_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]   cnt_d;
    logic                rsp_valid_q;
    logic                rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic [DATA_W-1:0]   rsp_rdata_d;

    // The storage array itself carries no reset; the clear sequencer owns
    // its initial contents.
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                handshake;
    logic                rd_hs;
    logic                wr_hs;
    logic [DATA_W-1:0]   lane_mask;
    logic [DATA_W-1:0]   rd_word;

    // Requests are only accepted while idle; a clear blocks the port.
    assign handshake = req_valid_i && (state_q == IDLE);
    assign rd_hs     = handshake && !req_we_i;
    assign wr_hs     = handshake && req_we_i;
    assign rd_word   = mem_q[req_addr_i];

    // Status outputs come straight from registered state.
    assign busy_o      = (state_q == CLEAR);
    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;

    // Expand the per-byte enables into a bit mask over the whole word.
    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < NB; i++) begin
            lane_mask[8*i +: 8] = {8{req_be_i[i]}};
        end
    end

    // Next-state logic: walk the clear counter, or wait for a clear request.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                cnt_d = '0;
                if (clear_start_i) begin
                    state_d = CLEAR;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // Read response: pulse valid for one cycle, hold the last data otherwise.
    always_comb begin
        rsp_valid_d = rd_hs;
        rsp_rdata_d = rsp_rdata_q;
        if (rd_hs) begin
            rsp_rdata_d = rd_word;
        end
    end

    // Control and response registers, forced to their idle values by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CLEAR;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Array update: zero one word per cycle while clearing, else masked write.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_hs) begin
            mem_q[req_addr_i] <= (rd_word & ~lane_mask) | (req_wdata_i & lane_mask);
        end
    end

endmodule

// File: tb/tb_data_mem_bank.sv
// tb_data_mem_bank: drives data_mem_bank with directed and random traffic
// and compares every cycle against a word-array reference model.
module tb_data_mem_bank;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_be = 2'b00;
    logic [5:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        clear_start = 1'b0;
    logic        busy;

    // Second instance with a 512-word array, used only for the deep clear.
    logic        rst9_n = 1'b0;
    logic        req_valid9 = 1'b0;
    logic        req_ready9;
    logic [8:0]  req_addr9 = '0;
    logic        rsp_valid9;
    logic [15:0] rsp_rdata9;
    logic        busy9;

    // Reference model state.
    logic [15:0] model [DEPTH];
    int          clearLeft;
    logic        expValid;
    logic [15:0] expData;

    int passCount = 0;
    int checkCount = 0;

    always #5 clk = ~clk;

    data_mem_bank #(.DATA_W(16), .ADDR_W(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_be_i     (req_be),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .rsp_valid_o  (rsp_valid),
        .rsp_rdata_o  (rsp_rdata),
        .clear_start_i(clear_start),
        .busy_o       (busy)
    );

    data_mem_bank #(.DATA_W(16), .ADDR_W(9)) dut9 (
        .clk          (clk),
        .rst_n        (rst9_n),
        .req_valid_i  (req_valid9),
        .req_ready_o  (req_ready9),
        .req_we_i     (1'b0),
        .req_be_i     (2'b00),
        .req_addr_i   (req_addr9),
        .req_wdata_i  (16'h0000),
        .rsp_valid_o  (rsp_valid9),
        .rsp_rdata_o  (rsp_rdata9),
        .clear_start_i(1'b0),
        .busy_o       (busy9)
    );

    // Count one comparison and report it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs (called at a falling edge), predict the
    // outcome from the model, let the rising edge happen, then check.
    task automatic applyStimulus(input logic v, input logic we, input logic [1:0] be,
                                 input logic [5:0] addr, input logic [15:0] wdata,
                                 input logic clr);
        logic        nextValid;
        logic [15:0] nextData;
        req_valid   = v;
        req_we      = we;
        req_be      = be;
        req_addr    = addr;
        req_wdata   = wdata;
        clear_start = clr;
        nextValid = 1'b0;
        nextData  = expData;
        if (v && clearLeft == 0) begin
            if (we) begin
                for (int i = 0; i < 2; i++) begin
                    if (be[i]) model[addr][8*i +: 8] = wdata[8*i +: 8];
                end
            end else begin
                nextValid = 1'b1;
                nextData  = model[addr];
            end
        end
        if (clearLeft > 0) begin
            clearLeft--;
        end else if (clr) begin
            clearLeft = DEPTH;
            foreach (model[k]) model[k] = 16'h0000;
        end
        @(posedge clk);
        @(negedge clk);
        expValid = nextValid;
        expData  = nextData;
        checkOutput("rspValid", rsp_valid, expValid);
        checkOutput("rspData", rsp_rdata, expData);
        checkOutput("busy", busy, clearLeft != 0);
        checkOutput("ready", req_ready, clearLeft == 0);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 2'b00, 6'd0, 16'h0000, 1'b0);
    endtask

    // Idle until req_ready rises, bounded; returns the number of edges waited.
    task automatic waitReady(output int n);
        n = 0;
        while (!req_ready && n < 2 * DEPTH + 16) begin
            idleCycle();
            n++;
        end
    endtask

    // Assert reset between edges, check the asynchronous reset values, release.
    task automatic resetDut();
        #2;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        clear_start = 1'b0;
        #1;
        checkOutput("rstReady", req_ready, 0);
        checkOutput("rstBusy", busy, 1);
        checkOutput("rstRspValid", rsp_valid, 0);
        checkOutput("rstRspData", rsp_rdata, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        clearLeft = DEPTH;
        expValid  = 1'b0;
        expData   = 16'h0000;
        foreach (model[k]) model[k] = 16'h0000;
    endtask

    // Handshake a read, then assert reset while its response would be visible.
    task automatic resetAfterRead(input logic [5:0] addr);
        req_valid   = 1'b1;
        req_we      = 1'b0;
        req_addr    = addr;
        clear_start = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        #1;
        checkOutput("rdRstRspValid", rsp_valid, 0);
        checkOutput("rdRstRspData", rsp_rdata, 0);
        checkOutput("rdRstBusy", busy, 1);
        checkOutput("rdRstReady", req_ready, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        clearLeft = DEPTH;
        expValid  = 1'b0;
        expData   = 16'h0000;
        foreach (model[k]) model[k] = 16'h0000;
    endtask

    initial begin
        int n;
        clearLeft = DEPTH;
        expValid  = 1'b0;
        expData   = 16'h0000;
        foreach (model[k]) model[k] = 16'h0000;

        @(negedge clk);
        resetDut();
        waitReady(n);
        checkOutput("resetClearLen", n, DEPTH);

        // Every word reads back zero after the initial clear.
        for (int a = 0; a < DEPTH; a++) applyStimulus(1'b1, 1'b0, 2'b00, 6'(a), 16'h0, 1'b0);
        idleCycle();

        // Full write then read-back on the following cycle.
        applyStimulus(1'b1, 1'b1, 2'b11, 6'd5, 16'hBEEF, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'b00, 6'd5, 16'h0000, 1'b0);
        checkOutput("beefValid", rsp_valid, 1);
        checkOutput("beefData", rsp_rdata, 16'hBEEF);

        // Byte-lane merge, then an all-lanes-disabled write that changes nothing.
        applyStimulus(1'b1, 1'b1, 2'b11, 6'd7, 16'h1234, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'b10, 6'd7, 16'hAB00, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'b00, 6'd7, 16'h0000, 1'b0);
        checkOutput("laneMerge", rsp_rdata, 16'hAB34);
        applyStimulus(1'b1, 1'b1, 2'b00, 6'd7, 16'hFFFF, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'b00, 6'd7, 16'h0000, 1'b0);
        checkOutput("zeroBe", rsp_rdata, 16'hAB34);

        // Back-to-back reads, then the last value is held.
        applyStimulus(1'b1, 1'b1, 2'b11, 6'd1, 16'h0011, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'b11, 6'd2, 16'h0022, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'b11, 6'd3, 16'h0033, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'b00, 6'd1, 16'h0000, 1'b0);
        checkOutput("b2b1", rsp_rdata, 16'h0011);
        applyStimulus(1'b1, 1'b0, 2'b00, 6'd2, 16'h0000, 1'b0);
        checkOutput("b2b2", rsp_rdata, 16'h0022);
        applyStimulus(1'b1, 1'b0, 2'b00, 6'd3, 16'h0000, 1'b0);
        checkOutput("b2b3", rsp_rdata, 16'h0033);
        idleCycle();
        checkOutput("holdValid", rsp_valid, 0);
        checkOutput("holdData", rsp_rdata, 16'h0033);

        // Clear requested alongside a write; a second pulse mid-clear is ignored.
        applyStimulus(1'b1, 1'b1, 2'b11, 6'd9, 16'h5555, 1'b1);
        checkOutput("clrBusy", busy, 1);
        for (int i = 0; i < 10; i++) idleCycle();
        applyStimulus(1'b0, 1'b0, 2'b00, 6'd0, 16'h0000, 1'b1);
        waitReady(n);
        checkOutput("clrLen", n + 11, DEPTH);
        applyStimulus(1'b1, 1'b0, 2'b00, 6'd9, 16'h0000, 1'b0);
        checkOutput("clrAddr9", rsp_rdata, 16'h0000);

        // Random traffic, including occasional clears, against the model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom % 4) != 0, 1'($urandom), 2'($urandom),
                          6'($urandom_range(0, 15)), 16'($urandom),
                          ($urandom % 60) == 0);
        end
        waitReady(n);

        // Reset in the middle of a clear restarts it from the beginning.
        resetDut();
        for (int i = 0; i < 30; i++) idleCycle();
        resetDut();
        waitReady(n);
        checkOutput("midClearRstLen", n, DEPTH);

        // Reset while a read response is in flight drops the response.
        applyStimulus(1'b1, 1'b1, 2'b11, 6'd4, 16'hC0DE, 1'b0);
        @(negedge clk);
        resetAfterRead(6'd4);
        waitReady(n);
        checkOutput("readRstLen", n, DEPTH);

        // Deep array: the clear walks all 512 words before the port opens.
        @(negedge clk);
        checkOutput("deepRstBusy", busy9, 1);
        checkOutput("deepRstReady", req_ready9, 0);
        rst9_n = 1'b1;
        n = 0;
        while (!req_ready9 && n < 1100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        checkOutput("deepClearLen", n, 512);
        req_addr9  = 9'($urandom_range(0, 511));
        req_valid9 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid9 = 1'b0;
        checkOutput("deepRspValid", rsp_valid9, 1);
        checkOutput("deepRspData", rsp_rdata9, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        checkOutput("deepRspDone", rsp_valid9, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/data_mem_bank.md
# data_mem_bank

Parametrised single-port data memory with a valid/ready request interface, byte-lane write masking, registered read response and a hardware clear sequencer. It replaces the fixed-size 16-bit data store on the CPU load/store path. Width and depth are generic. Contents are zeroed by the block itself after reset or on demand, so no memory image file is needed.

## Interface
- DATA_W, 16: word width in bits; must be a multiple of 8; byte lanes NB = DATA_W/8
- ADDR_W, 6: word address width; DEPTH = 2^ADDR_W words (6 → 64, 9 → 512)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = write, 0 = read
- req_be  in  NB  byte-lane write enables, lane i = bits [8i+7:8i]; ignored on reads
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  read data valid, one-cycle pulse per accepted read
- rsp_rdata  out  DATA_W  read data
- clear_start  in  1  request full-memory clear
- busy  out  1  clear sequence in progress

## Operation
- FSM states: CLEAR, IDLE. Reset enters CLEAR with clear counter = 0.
- CLEAR: each cycle writes 0 to mem[counter] and increments counter. The cycle that writes DEPTH-1 moves the FSM to IDLE; the counter wraps to 0.
- IDLE: req_ready = 1. A handshake (req_valid & req_ready) performs the request.
- Write: for each lane i with req_be[i] = 1, update that byte of mem[req_addr] at the handshake edge. Other lanes are unchanged. A write with req_be = 0 is accepted and has no effect.
- Read: mem[req_addr] is sampled at the handshake edge. Read-first semantics apply.
- Response path has no backpressure. Reads may be issued back-to-back, one per cycle.
- rsp_rdata holds the last read value until the next read response. Writes do not change it.
- clear_start is sampled only in IDLE. When high, the FSM enters CLEAR at the next edge with counter = 0.
  - A request that handshakes in the same cycle as clear_start is still completed.
  - Its write is later overwritten by the clear. Its read response is still delivered.
- clear_start is ignored while in CLEAR.
- busy = (state == CLEAR). req_ready = (state == IDLE). Both are decoded from registered state only.
- Simultaneous read and write are impossible: one request per cycle.

## Timing
- Reset values: req_ready 0, busy 1, rsp_valid 0, rsp_rdata 0, state CLEAR, counter 0. Memory contents are undefined until the clear completes.
- After rst_n deasserts, CLEAR lasts exactly DEPTH cycles. req_ready rises on the edge after the write to address DEPTH-1: edge DEPTH counting the first post-reset edge as 1.
- Read latency is 1. A read handshake at edge N gives rsp_valid = 1 and valid rsp_rdata between edges N and N+1. rsp_valid is 0 otherwise.
- Write latency is 1. A read of the same address handshaking at edge N+1 or later returns the new data.
- clear_start high in IDLE at edge N gives busy = 1 and req_ready = 0 after edge N. IDLE returns after edge N+DEPTH.
- rst_n assertion at any time, including mid-clear or with a read outstanding, immediately forces the reset values. The outstanding response is dropped. The clear restarts from address 0 after release.

## Test plan
- DATA_W=16, ADDR_W=6. Release reset → busy = 1 for 64 cycles; req_ready first 1 at edge 64. Then read every address → all return 0x0000 with rsp_valid pulsing exactly once per read.
- Write 0xBEEF to addr 5 with be=2'b11, then read addr 5 on the next cycle → rsp_valid next cycle, rsp_rdata = 0xBEEF.
- Write 0x1234 be=11 to addr 7, then 0xAB00 be=10 → read returns 0xAB34. Then write 0xFFFF with be=00 → read still returns 0xAB34.
- Back-to-back reads of addrs 1, 2, 3 holding 0x0011/0x0022/0x0033 → rsp_valid high three consecutive cycles with data 0x0011, 0x0022, 0x0033. After that, rsp_valid = 0 and rsp_rdata holds 0x0033.
- Assert clear_start together with a write of 0x5555 to addr 9 → write accepted and busy = 1 for 64 cycles. A read of addr 9 after req_ready returns returns 0x0000. clear_start pulsed mid-clear does not extend busy.
- Assert rst_n = 0 at clear cycle 30 and again one cycle after a read handshake → outputs go to reset values asynchronously and no rsp_valid appears. After release, busy lasts the full 64 cycles. Repeat the first scenario with ADDR_W=9 → 512 cycles.
